// File: rtl/regfile_pkg.sv
// Shared defaults, typedefs and the address-validity helper for the register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_BYPASS   = 1;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  // R0 is hard-wired to zero: never written, never reserved.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_DATA_W-1:0] data_t;

  // True when an address names a real, writable register. Compared at 32 bits
  // so the range test stays meaningful when NUM_REGS is not a power of two.
  function automatic logic reg_addr_ok(input int unsigned addr, input int unsigned num_regs);
    return (addr != ZERO_REG) && (addr < num_regs);
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux over the storage array, busy lookup,
// and same-cycle write forwarding (port B wins over port A).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic [ADDR_W-1:0]                i_addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  i_regs,
  input  logic [NUM_REGS-1:0]              i_busy,
  input  logic                             i_wa_acc,
  input  logic [ADDR_W-1:0]                i_wa_addr,
  input  logic [DATA_W-1:0]                i_wa_data,
  input  logic                             i_wb_acc,
  input  logic [ADDR_W-1:0]                i_wb_addr,
  input  logic [DATA_W-1:0]                i_wb_data,
  output logic [DATA_W-1:0]                o_data,
  output logic                             o_busy
);

  logic w_valid;
  logic w_hit_a;
  logic w_hit_b;

  assign w_valid = reg_addr_ok(32'(i_addr), NUM_REGS);
  // Accept flags already include enable, reset and address range.
  assign w_hit_a = (BYPASS != 0) && i_wa_acc && (i_wa_addr == i_addr);
  assign w_hit_b = (BYPASS != 0) && i_wb_acc && (i_wb_addr == i_addr);

  // Select forwarded or stored data; a forwarded value is by definition not pending.
  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (w_valid) begin
      if (w_hit_b) begin
        o_data = i_wb_data;
      end else if (w_hit_a) begin
        o_data = i_wa_data;
      end else begin
        o_data = i_regs[i_addr];
        o_busy = i_busy[i_addr];
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two write ports, NUM_RD combinational read ports and a
// per-register busy scoreboard used by issue to track pending producers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int BYPASS   = DEF_BYPASS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_enable,
  input  logic                       i_wa_en,
  input  logic [ADDR_W-1:0]          i_wa_addr,
  input  logic [DATA_W-1:0]          i_wa_data,
  input  logic                       i_wb_en,
  input  logic [ADDR_W-1:0]          i_wb_addr,
  input  logic [DATA_W-1:0]          i_wb_data,
  input  logic                       i_iss_en,
  input  logic [ADDR_W-1:0]          i_iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  output logic [NUM_REGS-1:0]        o_busy_vec
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_busy;

  logic w_wa_acc;
  logic w_wb_acc;
  logic w_iss_ok;

  // Reset is folded in so nothing is forwarded to the read ports while it is held.
  assign w_wa_acc = i_rst_n & i_enable & i_wa_en & reg_addr_ok(32'(i_wa_addr), NUM_REGS);
  assign w_wb_acc = i_rst_n & i_enable & i_wb_en & reg_addr_ok(32'(i_wb_addr), NUM_REGS);
  assign w_iss_ok = i_iss_en & reg_addr_ok(32'(i_iss_addr), NUM_REGS);

  // Register storage; B overrides A on an address collision, R0 stays at its reset zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_regs <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_wb_acc && (i_wb_addr == ADDR_W'(r))) begin
          r_regs[r] <= i_wb_data;
        end else if (w_wa_acc && (i_wa_addr == ADDR_W'(r))) begin
          r_regs[r] <= i_wa_data;
        end
      end
    end
  end

  // Scoreboard: a new reservation beats a retiring write on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else if (i_enable) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (w_iss_ok && (i_iss_addr == ADDR_W'(r))) begin
          r_busy[r] <= 1'b1;
        end else if ((w_wa_acc && (i_wa_addr == ADDR_W'(r))) ||
                     (w_wb_acc && (i_wb_addr == ADDR_W'(r)))) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign o_busy_vec = r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS)
    ) u_rd (
      .i_addr    (i_rd_addr[k*ADDR_W +: ADDR_W]),
      .i_regs    (r_regs),
      .i_busy    (r_busy),
      .i_wa_acc  (w_wa_acc),
      .i_wa_addr (i_wa_addr),
      .i_wa_data (i_wa_data),
      .i_wb_acc  (w_wb_acc),
      .i_wb_addr (i_wb_addr),
      .i_wb_data (i_wb_data),
      .o_data    (o_rd_data[k*DATA_W +: DATA_W]),
      .o_busy    (o_rd_busy[k])
    );
  end

endmodule
